// File: rtl/plab5_mcore_mem_domain_arb.sv
// Shares one bank request port between two security domains: round-robin (mode=0) or
// time-division slots with a guard band (mode=1). Define PLAB5_MCORE_MEM_DOMAIN_ARB_PERF_EN for perf counters.
module plab5_mcore_mem_domain_arb #(
    parameter int p_msg_nbits   = 77,
    parameter int p_resp_nbits  = 47,
    parameter int p_slot_cycles = 16,
    parameter int p_guard       = 4,
    parameter int p_max_outs    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,

    input  logic                    req_val_p0,
    output logic                    req_rdy_p0,
    input  logic [p_msg_nbits-1:0]  req_msg_p0,
    input  logic                    req_val_p1,
    output logic                    req_rdy_p1,
    input  logic [p_msg_nbits-1:0]  req_msg_p1,

    output logic                    out_val,
    input  logic                    out_rdy,
    output logic [p_msg_nbits-1:0]  out_msg,
    output logic                    out_domain,

    input  logic                    resp_in_val,
    output logic                    resp_in_rdy,
    input  logic [p_resp_nbits-1:0] resp_in_msg,
    input  logic                    resp_in_domain,

    output logic                    resp_val_p0,
    input  logic                    resp_rdy_p0,
    output logic [p_resp_nbits-1:0] resp_msg_p0,
    output logic                    resp_val_p1,
    input  logic                    resp_rdy_p1,
    output logic [p_resp_nbits-1:0] resp_msg_p1,

    output logic                    cur_owner,
    output logic                    err
`ifdef PLAB5_MCORE_MEM_DOMAIN_ARB_PERF_EN
    ,
    output logic [15:0]             perf_grants_p0,
    output logic [15:0]             perf_grants_p1,
    output logic [15:0]             perf_guard_stall
`endif
);

    localparam int SW = $clog2(p_slot_cycles);
    localparam int OW = $clog2(p_max_outs + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(p_slot_cycles - 1);
    localparam logic [SW:0]   WIN_END   = (SW+1)'(p_slot_cycles - p_guard);
    localparam logic [OW-1:0] OUTS_MAX  = OW'(p_max_outs);

    function automatic logic [OW-1:0] outs_next(input logic [OW-1:0] cnt,
                                                input logic inc, input logic dec);
        logic [OW-1:0] r;
        r = cnt;
        if (inc && !dec)
            r = cnt + OW'(1);
        else if (dec && !inc && cnt != '0)
            r = cnt - OW'(1);
        return r;
    endfunction

    function automatic logic outs_underflow(input logic [OW-1:0] cnt,
                                            input logic inc, input logic dec);
        return dec & ~inc & (cnt == '0);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    logic [SW-1:0] slot_cnt;
    logic          slot_owner;
    logic          rr_last;
    logic [OW-1:0] outs_d0;
    logic [OW-1:0] outs_d1;
    logic          hold_vld;
    logic          hold_dom;
    logic          mode_q;

    logic          elig0;
    logic          elig1;
    logic          owner_elig;
    logic          in_window;
    logic          slot_wrap;
    logic          sel;
    logic          grant_ok;
    logic          fire;
    logic          fire0;
    logic          fire1;
    logic          resp_fire;
    logic          resp_fire0;
    logic          resp_fire1;
    logic          guard_block;

    assign elig0      = req_val_p0 & (outs_d0 < OUTS_MAX);
    assign elig1      = req_val_p1 & (outs_d1 < OUTS_MAX);
    assign owner_elig = slot_owner ? elig1 : elig0;
    assign in_window  = {1'b0, slot_cnt} < WIN_END;
    assign slot_wrap  = (slot_cnt == SLOT_LAST);

    // A held grant survives the guard band; only new grants are suppressed there.
    always_comb begin
        sel      = 1'b0;
        grant_ok = 1'b0;
        if (mode_q) begin
            sel      = slot_owner;
            grant_ok = owner_elig & (hold_vld | in_window);
        end else begin
            if (hold_vld)
                sel = hold_dom;
            else if (elig0 && elig1)
                sel = ~rr_last;
            else
                sel = elig1;
            grant_ok = sel ? elig1 : elig0;
        end
    end

    assign guard_block = mode_q & owner_elig & ~hold_vld & ~in_window;

    assign out_val    = reset & grant_ok;
    assign out_msg    = sel ? req_msg_p1 : req_msg_p0;
    assign out_domain = sel;
    assign req_rdy_p0 = out_val & ~sel & out_rdy;
    assign req_rdy_p1 = out_val &  sel & out_rdy;
    assign fire       = out_val & out_rdy;
    assign fire0      = fire & ~sel;
    assign fire1      = fire &  sel;

    assign resp_in_rdy = reset & (resp_in_domain ? resp_rdy_p1 : resp_rdy_p0);
    assign resp_val_p0 = reset & resp_in_val & ~resp_in_domain;
    assign resp_val_p1 = reset & resp_in_val &  resp_in_domain;
    assign resp_msg_p0 = resp_in_msg;
    assign resp_msg_p1 = resp_in_msg;
    assign resp_fire   = resp_in_val & resp_in_rdy;
    assign resp_fire0  = resp_fire & ~resp_in_domain;
    assign resp_fire1  = resp_fire &  resp_in_domain;

    assign cur_owner = slot_owner;

    // Mode is sampled every edge (including during reset) so it takes effect one cycle later.
    always_ff @(posedge clk) begin
        mode_q <= mode;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt   <= '0;
            slot_owner <= 1'b0;
            rr_last    <= 1'b1;
            outs_d0    <= '0;
            outs_d1    <= '0;
            hold_vld   <= 1'b0;
            hold_dom   <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (slot_wrap) begin
                slot_cnt   <= '0;
                slot_owner <= ~slot_owner;
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end

            // Pending grants are dropped on a mode change or on a TDM slot wrap.
            hold_vld <= out_val & ~out_rdy & (mode == mode_q) & ~(mode_q & slot_wrap);
            hold_dom <= sel;

            if (fire && !mode_q)
                rr_last <= sel;

            outs_d0 <= outs_next(outs_d0, fire0, resp_fire0);
            outs_d1 <= outs_next(outs_d1, fire1, resp_fire1);
            if (outs_underflow(outs_d0, fire0, resp_fire0) ||
                outs_underflow(outs_d1, fire1, resp_fire1))
                err <= 1'b1;
        end
    end

`ifdef PLAB5_MCORE_MEM_DOMAIN_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_grants_p0   <= '0;
            perf_grants_p1   <= '0;
            perf_guard_stall <= '0;
        end else begin
            perf_grants_p0   <= sat_inc16(perf_grants_p0, fire0);
            perf_grants_p1   <= sat_inc16(perf_grants_p1, fire1);
            perf_guard_stall <= sat_inc16(perf_guard_stall, guard_block);
        end
    end
`endif

endmodule
